// File: rtl/div_pkg.sv
// div_pkg: shared widths and FSM state encoding for the sequential divider.
package div_pkg;
    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = 5;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/seq_divider16_if.sv
// seq_divider16_if: operand/result handshake bundle for seq_divider16.
interface seq_divider16_if;
    import div_pkg::*;
    logic                 in_valid, in_ready, out_valid, out_ready, div_by_zero;
    logic [DIV_WIDTH-1:0] dividend, divisor, quotient, remainder;
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
module div_step
    import div_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] i_rem,
    input  logic                 i_bit,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic [DIV_WIDTH-1:0] o_rem,
    output logic                 o_qbit
);
    logic [DIV_WIDTH:0]   w_shift;
    logic [DIV_WIDTH+1:0] w_diff;
    assign w_shift = {i_rem, i_bit};
    // shifted value can reach 17 bits, so the borrow lives one bit above it
    assign w_diff  = {1'b0, w_shift} - {2'b00, i_div};
    assign o_qbit  = ~w_diff[DIV_WIDTH+1];
    assign o_rem   = DIV_WIDTH'(o_qbit ? w_diff : {1'b0, w_shift});
endmodule

// File: rtl/seq_divider16.sv
// seq_divider16: 16-bit unsigned restoring divider, one quotient bit per clock.
module seq_divider16
    import div_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    seq_divider16_if.slave bus
);
    state_t               r_state, w_next;
    logic [DIV_WIDTH-1:0] r_dvd, r_dsr, r_rem, r_quo, w_rem;
    logic [DIV_CNT_W-1:0] r_cnt;
    logic                 r_dz, w_qbit, w_accept, w_zero;

    assign w_accept = bus.in_valid && r_state == IDLE;
    assign w_zero   = bus.divisor == '0;

    div_step u_step (
        .i_rem  (r_rem),
        .i_bit  (r_dvd[DIV_WIDTH-1]),
        .i_div  (r_dsr),
        .o_rem  (w_rem),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        if (w_accept)
            w_next = w_zero ? DONE : RUN;
        else if (r_state == RUN && r_cnt == DIV_CNT_W'(DIV_WIDTH - 1))
            w_next = DONE;
        else if (r_state == DONE && bus.out_ready)
            w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd <= '0;
            r_dsr <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
            r_dz  <= 1'b0;
        end else if (w_accept) begin
            r_dvd <= bus.dividend;
            r_dsr <= bus.divisor;
            r_cnt <= '0;
            r_dz  <= w_zero;
            r_rem <= w_zero ? bus.dividend : '0;
            r_quo <= w_zero ? '1 : '0;
        end else if (r_state == RUN) begin
            r_dvd <= r_dvd << 1;
            r_rem <= w_rem;
            r_quo <= {r_quo[DIV_WIDTH-2:0], w_qbit};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.in_ready    = r_state == IDLE;
    assign bus.out_valid   = r_state == DONE;
    assign bus.quotient    = r_quo;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dz;
endmodule

// File: tb/tb_seq_divider16.sv
// tb_seq_divider16: directed and random checks of seq_divider16 against an arithmetic model.
module tb_seq_divider16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    seq_divider16_if bus ();
    seq_divider16 dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called from IDLE at #1 after an edge; returns after the result retires.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b, input bit pulse);
        int n;
        logic [15:0] eq, er;
        eq = (b == 0) ? 16'hFFFF : a / b;
        er = (b == 0) ? a : a % b;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            if (pulse) check("busy_in_ready", 32'(bus.in_ready), 32'd0);
            bus.in_valid = pulse && n == 3;
            bus.dividend = ~a;
            bus.divisor  = 16'd3;
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        check("edges_to_valid", 32'(n), (b == 0) ? 32'd0 : 32'd16);
        check("quotient", 32'(bus.quotient), 32'(eq));
        check("remainder", 32'(bus.remainder), 32'(er));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(b == 0));
        tick();
        bus.out_ready = 1'b0;
        check("retired", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int n;
        bit seen;
        logic [15:0] a, b;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_quotient", 32'(bus.quotient), 32'd0);
        check("rst_remainder", 32'(bus.remainder), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);

        run_div(16'd100, 16'd7, 1'b0);
        run_div(16'h1234, 16'd0, 1'b0);
        run_div(16'hFFFF, 16'h8001, 1'b0);
        run_div(16'd50000, 16'd123, 1'b1);

        // backpressure: 1000/33 = 30 rem 10
        bus.in_valid = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 16'd33;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        check("bp_edges", 32'(n), 32'd16);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_quotient", 32'(bus.quotient), 32'd30);
            check("bp_remainder", 32'(bus.remainder), 32'd10);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.dividend  = 16'd9;
        bus.divisor   = 16'd2;
        check("hs_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("hs_out_valid", 32'(bus.out_valid), 32'd0);
        check("hs_idle", 32'(bus.in_ready), 32'd1);

        // reset at RUN step 8
        bus.in_valid = 1'b1;
        bus.dividend = 16'd500;
        bus.divisor  = 16'd3;
        tick();
        bus.in_valid = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_quotient", 32'(bus.quotient), 32'd0);
        check("abort_remainder", 32'(bus.remainder), 32'd0);
        check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen |= bus.out_valid;
        end
        check("abort_no_valid", 32'(seen), 32'd0);

        // reset wins over in_valid
        rst = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_wins", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 4000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 7))
                0: b = 16'd1;
                1: a = 16'd0;
                2: b = 16'd0;
                3: b = b | 16'h8000;
                4: b = 16'($urandom_range(1, 15));
                default: ;
            endcase
            run_div(a, b, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
